// File: rtl/voice_pkg.sv
// rtl/voice_pkg.sv - shared voice constants, FSM state type and select-width helper
package voice_pkg;

  localparam int VOICE_NUM_CH = 24;
  localparam int VOICE_DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Index width able to address n channels; never below one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/voice_chan_reg.sv
// rtl/voice_chan_reg.sv - one voice parameter holding register with its update strobe
module voice_chan_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              clr,
  output logic [DATA_W-1:0] q,
  output logic              upd
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              upd_q, upd_d;

  // ld and clr are never both high: loads only occur outside the clear sequence.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (ld) begin
      data_d = ld_data;
    end
    upd_d = ld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      upd_q  <= upd_d;
    end
  end

  assign q   = data_q;
  assign upd = upd_q;

endmodule

// File: rtl/voice_param_router.sv
// rtl/voice_param_router.sv - routes or broadcasts parameter words to per-voice registers, with sequenced clear
module voice_param_router
  import voice_pkg::*;
#(
  parameter int NUM_CH = VOICE_NUM_CH,
  parameter int DATA_W = VOICE_DATA_W,
  parameter int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic                     wr_bcast,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     err_sel,
  output logic [NUM_CH-1:0]        upd,
  output logic [NUM_CH*DATA_W-1:0] out_bus
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] clr_idx_q, clr_idx_d;
  logic             err_sel_q, err_sel_d;
  logic             accept;
  logic             in_range;
  logic [NUM_CH-1:0] ld_vec;
  logic [NUM_CH-1:0] clr_vec;

  // A pending clear request wins over a write in the same cycle.
  assign busy     = (state_q == CLEAR);
  assign wr_ready = (state_q == IDLE) && !clr_req;
  assign accept   = wr_valid && wr_ready;
  assign in_range = ({1'b0, wr_sel} < (SEL_W+1)'(NUM_CH));

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        if (clr_idx_q == SEL_W'(NUM_CH - 1)) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + SEL_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  // Out-of-range selects are flagged but leave every channel untouched.
  always_comb begin
    err_sel_d = accept && !wr_bcast && !in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
      err_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      err_sel_q <= err_sel_d;
    end
  end

  assign err_sel = err_sel_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign ld_vec[i]  = accept && (wr_bcast || (wr_sel == SEL_W'(i)));
    assign clr_vec[i] = busy && (clr_idx_q == SEL_W'(i));

    voice_chan_reg #(
      .DATA_W (DATA_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld      (ld_vec[i]),
      .ld_data (wr_data),
      .clr     (clr_vec[i]),
      .q       (out_bus[i*DATA_W +: DATA_W]),
      .upd     (upd[i])
    );
  end

endmodule

// File: tb/tb_voice_param_router.sv
// tb/tb_voice_param_router.sv - self-checking bench for voice_param_router against a behavioural channel model
module tb_voice_param_router;

  localparam int N  = 24;
  localparam int DW = 8;
  localparam int SW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_valid;
  logic            wr_ready;
  logic [SW-1:0]   wr_sel;
  logic            wr_bcast;
  logic [DW-1:0]   wr_data;
  logic            clr_req;
  logic            busy;
  logic            err_sel;
  logic [N-1:0]    upd;
  logic [N*DW-1:0] out_bus;

  int tests = 0;
  int fails = 0;

  // Behavioural model: channel contents, remaining clear cycles, expected strobes.
  logic [DW-1:0] m_ch [N];
  int            m_clr_left;
  logic [N-1:0]  m_upd;
  logic          m_err;

  always #5 clk = ~clk;

  voice_param_router dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_bcast (wr_bcast),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .err_sel  (err_sel),
    .upd      (upd),
    .out_bus  (out_bus)
  );

  function automatic logic [N*DW-1:0] model_bus();
    logic [N*DW-1:0] b;
    for (int i = 0; i < N; i++) b[i*DW +: DW] = m_ch[i];
    return b;
  endfunction

  task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_ch[i] = '0;
    m_clr_left = 0;
    m_upd      = '0;
    m_err      = 1'b0;
  endtask

  // One clock cycle: drive at the negedge, check ready/busy, then check registered results at the next negedge.
  task automatic step(input bit v, input int sel, input bit b, input logic [DW-1:0] d,
                      input bit c, output bit acc);
    bit exp_ready;
    wr_valid = v;
    wr_sel   = SW'(sel);
    wr_bcast = b;
    wr_data  = d;
    clr_req  = c;
    #1;
    exp_ready = (m_clr_left == 0) && !c;
    check("wr_ready", N*DW'(wr_ready), N*DW'(exp_ready));
    check("busy", N*DW'(busy), N*DW'(m_clr_left != 0));
    acc   = v && exp_ready;
    m_upd = '0;
    m_err = 1'b0;
    if (m_clr_left > 0) begin
      m_ch[N - m_clr_left] = '0;
      m_clr_left--;
    end else if (c) begin
      m_clr_left = N;
    end else if (acc) begin
      if (b) begin
        for (int i = 0; i < N; i++) m_ch[i] = d;
        m_upd = '1;
      end else if (sel < N) begin
        m_ch[sel]  = d;
        m_upd[sel] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    @(negedge clk);
    check("out_bus", out_bus, model_bus());
    check("upd", N*DW'(upd), N*DW'(m_upd));
    check("err_sel", N*DW'(err_sel), N*DW'(m_err));
  endtask

  task automatic idle_steps(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(0, 0, 0, 8'h00, 0, acc);
  endtask

  task automatic fill_all();
    bit acc;
    for (int i = 0; i < N; i++) step(1, i, 0, DW'($urandom), 0, acc);
  endtask

  initial begin
    bit            acc;
    bit            pend_v;
    int            pend_sel;
    bit            pend_b;
    logic [DW-1:0] pend_d;
    int            tries;

    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_sel   = '0;
    wr_bcast = 1'b0;
    wr_data  = '0;
    clr_req  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_out_bus", out_bus, '0);
    check("reset_upd", N*DW'(upd), '0);
    check("reset_err", N*DW'(err_sel), '0);
    check("reset_busy", N*DW'(busy), '0);
    rst_n = 1'b1;
    @(negedge clk);

    step(1, 5, 0, 8'h3C, 0, acc);
    step(1, 0, 1, 8'hA5, 0, acc);
    step(1, 25, 0, 8'h11, 0, acc);
    step(1, 31, 0, 8'h22, 0, acc);
    step(1, 24, 0, 8'h33, 0, acc);
    step(1, 23, 0, 8'h5A, 0, acc);
    idle_steps(2);

    fill_all();
    step(0, 0, 0, 8'h00, 1, acc);
    for (int k = 0; k < N; k++) step(1, k % N, k[0], DW'($urandom), k[1], acc);
    idle_steps(1);

    fill_all();
    pend_v = 1'b1; pend_sel = 3; pend_b = 1'b0; pend_d = 8'h77;
    step(pend_v, pend_sel, pend_b, pend_d, 1, acc);
    check("clr_beats_write", N*DW'(acc), '0);
    tries = 0;
    while (!acc && tries < 40) begin
      step(pend_v, pend_sel, pend_b, pend_d, 0, acc);
      tries++;
    end
    check("held_write_accepted", N*DW'(acc), N*DW'(1'b1));
    check("ch3_after_retry", N*DW'(out_bus[3*DW +: DW]), N*DW'(8'h77));

    pend_v = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!pend_v && ($urandom_range(0, 3) != 0)) begin
        pend_v   = 1'b1;
        pend_sel = $urandom_range(0, 31);
        pend_b   = ($urandom_range(0, 7) == 0);
        pend_d   = DW'($urandom);
      end
      step(pend_v, pend_sel, pend_b, pend_d, $urandom_range(0, 39) == 0, acc);
      if (acc) pend_v = 1'b0;
    end
    idle_steps(N + 1);

    fill_all();
    step(0, 0, 0, 8'h00, 1, acc);
    idle_steps(10);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midclr_rst_out_bus", out_bus, '0);
    check("midclr_rst_upd", N*DW'(upd), '0);
    check("midclr_rst_err", N*DW'(err_sel), '0);
    check("midclr_rst_busy", N*DW'(busy), '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 7, 0, 8'h42, 0, acc);
    check("post_rst_accept", N*DW'(acc), N*DW'(1'b1));
    idle_steps(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
